// File: rtl/led_fade_pwm.sv
// led_fade_pwm
// Three-channel fade/PWM generator for an RGB LED driver. Each channel ramps
// its brightness level up while its enable is high and down while it is low,
// one step per prescaler tick, and emits a glitch-free PWM waveform whose
// duty is latched only at PWM period boundaries.
//
// Optional feature macro: LED_FADE_GAMMA_EN
//   defined   : PWM compare value = (level*level) >> PWM_BITS, level MAX -> MAX
//   undefined : PWM compare value = level (no multiplier)
//
// Parameters
//   PWM_BITS  width of PWM counter and brightness level (MAX = 2^PWM_BITS-1)
//   PRESCALE  clk cycles per fade step (>= 1)
//
// Ports
//   clk        system clock
//   rst        asynchronous, active-high reset
//   en_in      [2:0] per-channel target (1 = fade to full, 0 = fade to off)
//   pwm_out    [2:0] registered PWM drive per channel
//   level_out  [3*PWM_BITS-1:0] raw brightness, channel n at [n*PWM_BITS +: PWM_BITS]
//   fading     [2:0] channel state is RISING or FALLING
//   steady_on  [2:0] channel state is ON
//
// Interface: en_in is a level, sampled every clk edge (no handshake); all
// outputs are valid every cycle. fading/steady_on expose the per-channel FSM.
module led_fade_pwm #(
  parameter int PWM_BITS = 8,
  parameter int PRESCALE = 187500
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [2:0]              en_in,
  output logic [2:0]              pwm_out,
  output logic [3*PWM_BITS-1:0]   level_out,
  output logic [2:0]              fading,
  output logic [2:0]              steady_on
);

  localparam logic [PWM_BITS-1:0] MAX = '1;
  localparam logic [PWM_BITS-1:0] ZERO = '0;
  localparam logic [PWM_BITS-1:0] ONE = PWM_BITS'(1);
  localparam logic [PWM_BITS-1:0] MAX_M1 = MAX - ONE;
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  typedef enum logic [1:0] {
    S_OFF     = 2'd0,
    S_RISING  = 2'd1,
    S_ON      = 2'd2,
    S_FALLING = 2'd3
  } state_t;

  // Fade-step prescaler. With PRESCALE == 1, PS_LAST is 0 and tick is
  // asserted every cycle.
  logic [PS_W-1:0] presc;
  logic            tick;

  assign tick = (presc == PS_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  // Free-running PWM counter, shared by all channels; wraps MAX -> 0.
  logic [PWM_BITS-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  for (genvar ch = 0; ch < 3; ch++) begin : g_ch
    state_t              state;
    logic [PWM_BITS-1:0] level;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] cmp;
    logic                pwm_r;

`ifdef LED_FADE_GAMMA_EN
    // Square-law curve for a perceptually linear fade; full level is forced
    // to full duty so the LED reaches constant-on.
    logic [2*PWM_BITS-1:0] sq;
    assign sq  = level * level;
    assign cmp = (level == MAX) ? MAX : sq[2*PWM_BITS-1:PWM_BITS];
`else
    assign cmp = level;
`endif

    // Fade FSM. A reversal only changes the state; the level continues from
    // where it is on the following ticks. The guards on MAX/0 keep the level
    // from wrapping when a reversal happens at an end point.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= S_OFF;
        level <= '0;
      end else begin
        case (state)
          S_OFF: begin
            if (en_in[ch]) state <= S_RISING;
          end
          S_RISING: begin
            if (!en_in[ch]) begin
              state <= S_FALLING;
            end else if (tick) begin
              if (level != MAX) level <= level + ONE;
              if (level == MAX || level == MAX_M1) state <= S_ON;
            end
          end
          S_ON: begin
            if (!en_in[ch]) state <= S_FALLING;
          end
          S_FALLING: begin
            if (en_in[ch]) begin
              state <= S_RISING;
            end else if (tick) begin
              if (level != ZERO) level <= level - ONE;
              if (level == ZERO || level == ONE) state <= S_OFF;
            end
          end
          default: state <= S_OFF;
        endcase
      end
    end

    // Duty is only reloaded on the last count of a period, so a level change
    // never produces a shortened or stretched pulse mid-period.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        duty  <= '0;
        pwm_r <= 1'b0;
      end else begin
        if (cnt == MAX) duty <= cmp;
        pwm_r <= (duty == MAX) | (cnt < duty);
      end
    end

    assign pwm_out[ch]                          = pwm_r;
    assign level_out[ch*PWM_BITS +: PWM_BITS]   = level;
    assign fading[ch]    = (state == S_RISING) || (state == S_FALLING);
    assign steady_on[ch] = (state == S_ON);
  end

endmodule

// File: tb/tb_led_fade_pwm.sv
// Testbench for led_fade_pwm. Two instances share one en_in/rst stream:
// dut_a (PWM_BITS=4, PRESCALE=2) and dut_b (PWM_BITS=8, PRESCALE=3).
// A behavioural model predicts every output after every clock edge; the
// driver pushes predictions into per-instance queues and a monitor pops and
// compares them on the falling edge.
module tb_led_fade_pwm;

  localparam int BA = 4;
  localparam int PA = 2;
  localparam int BB = 8;
  localparam int PB = 3;
  localparam int WA = 9 + 3*BA;
  localparam int WB = 9 + 3*BB;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] en = 3'b000;
  always #5 clk = ~clk;

  logic [2:0]      pwm_a, fad_a, st_a;
  logic [3*BA-1:0] lvl_a;
  logic [2:0]      pwm_b, fad_b, st_b;
  logic [3*BB-1:0] lvl_b;

  led_fade_pwm #(.PWM_BITS(BA), .PRESCALE(PA)) dut_a (
    .clk(clk), .rst(rst), .en_in(en),
    .pwm_out(pwm_a), .level_out(lvl_a), .fading(fad_a), .steady_on(st_a)
  );

  led_fade_pwm #(.PWM_BITS(BB), .PRESCALE(PB)) dut_b (
    .clk(clk), .rst(rst), .en_in(en),
    .pwm_out(pwm_b), .level_out(lvl_b), .fading(fad_b), .steady_on(st_b)
  );

  // behavioural model: a channel is either settled (at 0 or MAX) or moving
  // toward the side selected by 'up'.
  typedef struct {
    int presc;
    int cnt;
    int lvl[3];
    bit moving[3];
    bit up[3];
    int duty[3];
    bit pwm[3];
  } mdl_t;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.presc = 0;
    m.cnt   = 0;
    for (int ch = 0; ch < 3; ch++) begin
      m.lvl[ch] = 0; m.moving[ch] = 1'b0; m.up[ch] = 1'b0;
      m.duty[ch] = 0; m.pwm[ch] = 1'b0;
    end
    return m;
  endfunction

  function automatic int cmp_of(int lvl, int maxv, int bits);
`ifdef LED_FADE_GAMMA_EN
    if (lvl == maxv) return maxv;
    return (lvl * lvl) >> bits;
`else
    return lvl;
`endif
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int bits, int pres, logic [2:0] e);
    mdl_t n;
    int maxv;
    bit tick;
    n    = m;
    maxv = (1 << bits) - 1;
    tick = (m.presc == pres - 1);
    n.presc = (m.presc + 1) % pres;
    n.cnt   = (m.cnt + 1) % (maxv + 1);
    for (int ch = 0; ch < 3; ch++) begin
      n.pwm[ch] = (m.duty[ch] == maxv) || (m.cnt < m.duty[ch]);
      if (m.cnt == maxv) n.duty[ch] = cmp_of(m.lvl[ch], maxv, bits);
      if (!m.moving[ch]) begin
        if (e[ch] != m.up[ch]) begin
          n.moving[ch] = 1'b1;
          n.up[ch]     = e[ch];
        end
      end else if (e[ch] != m.up[ch]) begin
        n.up[ch] = e[ch];
      end else if (tick) begin
        if (m.up[ch]) begin
          n.lvl[ch] = (m.lvl[ch] < maxv) ? m.lvl[ch] + 1 : maxv;
          if (n.lvl[ch] == maxv) n.moving[ch] = 1'b0;
        end else begin
          n.lvl[ch] = (m.lvl[ch] > 0) ? m.lvl[ch] - 1 : 0;
          if (n.lvl[ch] == 0) n.moving[ch] = 1'b0;
        end
      end
    end
    return n;
  endfunction

  // layout: {level, steady_on, fading, pwm}
  function automatic logic [32:0] pack(mdl_t m, int bits);
    logic [32:0] v;
    v = '0;
    for (int ch = 0; ch < 3; ch++) begin
      v[ch]     = m.pwm[ch];
      v[3 + ch] = m.moving[ch];
      v[6 + ch] = !m.moving[ch] && m.up[ch];
      for (int b = 0; b < bits; b++) begin
        v[9 + ch*bits + b] = ((m.lvl[ch] >> b) & 1) != 0;
      end
    end
    return v;
  endfunction

  // scoreboard
  logic [WA-1:0] exp_qa[$];
  logic [WB-1:0] exp_qb[$];
  int vectors = 0;
  int miscompares = 0;
  mdl_t ma, mb;

  // driver: advance the model over the edge just taken, apply the next
  // inputs, then queue what the DUT must show before the next edge.
  task automatic cycle(input logic next_rst, input logic [2:0] next_en);
    @(posedge clk);
    #1;
    if (rst) begin
      ma = mdl_reset();
      mb = mdl_reset();
    end else begin
      ma = mdl_step(ma, BA, PA, en);
      mb = mdl_step(mb, BB, PB, en);
    end
    rst = next_rst;
    en  = next_en;
    if (rst) begin
      ma = mdl_reset();
      mb = mdl_reset();
    end
    exp_qa.push_back(WA'(pack(ma, BA)));
    exp_qb.push_back(WB'(pack(mb, BB)));
  endtask

  task automatic hold(input logic [2:0] e, input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, e);
  endtask

  // monitor
  initial begin
    logic [WA-1:0] ea, aa;
    logic [WB-1:0] eb, ab;
    forever begin
      @(negedge clk);
      if (exp_qa.size() != 0) begin
        ea = exp_qa.pop_front();
        aa = {lvl_a, st_a, fad_a, pwm_a};
        vectors++;
        if (aa !== ea) begin
          miscompares++;
          if (miscompares <= 30)
            $display("FAIL dut_a_outputs t=%0t got=%h expected=%h", $time, aa, ea);
        end
      end
      if (exp_qb.size() != 0) begin
        eb = exp_qb.pop_front();
        ab = {lvl_b, st_b, fad_b, pwm_b};
        vectors++;
        if (ab !== eb) begin
          miscompares++;
          if (miscompares <= 30)
            $display("FAIL dut_b_outputs t=%0t got=%h expected=%h", $time, ab, eb);
        end
      end
    end
  end

  // stimulus
  initial begin
    int len;
    logic [2:0] e;
    ma = mdl_reset();
    mb = mdl_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 3'b000);
    hold(3'b000, 100);            // idle after reset
    hold(3'b001, 40);             // full ramp on channel 0 (dut_a)
    cycle(1'b1, 3'b001);          // reset mid-fade
    cycle(1'b1, 3'b001);
    hold(3'b010, 13);             // channel 1 part way up
    hold(3'b000, 60);             // reversal and fall back to off
    hold(3'b101, 900);            // lockstep full ramps on both instances
    hold(3'b000, 900);
    for (int s = 0; s < 60; s++) begin
      e   = 3'($urandom_range(0, 7));
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                        : $urandom_range(4, 400);
      if ($urandom_range(0, 19) == 0) cycle(1'b1, e);
      hold(e, len);
    end
    hold(3'b000, 4);
    repeat (2) @(negedge clk);
    if (exp_qa.size() != 0 || exp_qb.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain got=%0d/%0d expected=0/0", exp_qa.size(), exp_qb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
